// File: rtl/attack_scheduler_pkg.sv
// Shared types and constants for the attack scheduler: per-player timeline
// states, default frame counts and the frame counter width.
package attack_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WINDUP   = 2'd1,
      STRIKE   = 2'd2,
      COOLDOWN = 2'd3
   } atk_state_t;

   localparam int WINDUP_FRAMES_DEF   = 4;
   localparam int COOLDOWN_FRAMES_DEF = 30;
   localparam int DMG_BASE_DEF        = 1;

   // Wide enough for a doubled (parried) cooldown.
   localparam int CNT_W = $clog2(2 * COOLDOWN_FRAMES_DEF + 1);

   localparam int C1 = 0;
   localparam int C2 = 1;

   function automatic int cnt_width(input int windup, input int cooldown);
      int top_val;
      top_val = (windup > 2 * cooldown) ? windup : 2 * cooldown;
      return (top_val < 1) ? 1 : $clog2(top_val + 1);
   endfunction

endpackage

// File: rtl/attack_scheduler_if.sv
// Play-side bundle of the attack scheduler; parry_pulse exists only when
// PARRY_EN is defined.
interface attack_scheduler_if;
   logic       enable;
   logic       frame_tick;
   logic [1:0] atk_req;
   logic       touching;
   logic       hit_valid;
   logic       hit_target;
   logic [3:0] hit_dmg;
   logic [1:0] busy;
   logic [1:0] cooling;
`ifdef PARRY_EN
   logic       parry_pulse;

   modport master (output enable, frame_tick, atk_req, touching,
                   input  hit_valid, hit_target, hit_dmg, busy, cooling, parry_pulse);
   modport slave  (input  enable, frame_tick, atk_req, touching,
                   output hit_valid, hit_target, hit_dmg, busy, cooling, parry_pulse);
`else
   modport master (output enable, frame_tick, atk_req, touching,
                   input  hit_valid, hit_target, hit_dmg, busy, cooling);
   modport slave  (input  enable, frame_tick, atk_req, touching,
                   output hit_valid, hit_target, hit_dmg, busy, cooling);
`endif
endinterface

// File: rtl/attack_timeline.sv
// One player's attack timeline: key edge detect, IDLE/WINDUP/STRIKE/COOLDOWN
// state machine and the shared frame counter.
module attack_timeline
   import attack_pkg::*;
#(
   parameter int WINDUP_FRAMES   = WINDUP_FRAMES_DEF,
   parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
   parameter int CW              = CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       frame_tick,
   input  logic       atk_key,
   input  logic       grant,
   input  logic       double_cd,
   output logic       strike_req,
   output atk_state_t state
);

   localparam logic [CW-1:0] WINDUP_LOAD = CW'(WINDUP_FRAMES);
   localparam logic [CW-1:0] CD_LOAD     = CW'(COOLDOWN_FRAMES);
   localparam logic [CW-1:0] CD2_LOAD    = CW'(2 * COOLDOWN_FRAMES);

   atk_state_t    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          key_prev_reg, key_prev_next;
   logic          launch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         key_prev_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         key_prev_reg <= key_prev_next;
      end
   end

   // Every state entry loads the counter, so a coincident frame_tick is lost.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      key_prev_next = atk_key;
      launch        = atk_key & ~key_prev_reg;
      if (!enable) begin
         state_next    = IDLE;
         cnt_next      = '0;
         key_prev_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (launch) begin
               cnt_next   = WINDUP_LOAD;
               state_next = (WINDUP_FRAMES == 0) ? STRIKE : WINDUP;
            end
            WINDUP: if (frame_tick) begin
               if (cnt_reg == CW'(1)) begin
                  state_next = STRIKE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg - CW'(1);
               end
            end
            STRIKE: if (grant) begin
               state_next = COOLDOWN;
               cnt_next   = double_cd ? CD2_LOAD : CD_LOAD;
            end
            COOLDOWN: if (frame_tick) begin
               if (cnt_reg == CW'(1)) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg - CW'(1);
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      strike_req = (state_reg == STRIKE);
      state      = state_reg;
   end

endmodule

// File: rtl/attack_scheduler.sv
// Two attack timelines sharing one registered damage port through a
// round-robin arbiter. Optional parry landing is enabled by PARRY_EN.
module attack_scheduler
   import attack_pkg::*;
#(
   parameter int WINDUP_FRAMES   = WINDUP_FRAMES_DEF,
   parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF,
   parameter int DMG_BASE        = DMG_BASE_DEF
) (
   input logic               clk,
   input logic               reset,
   attack_scheduler_if.slave bus
);

   localparam int         CW  = cnt_width(WINDUP_FRAMES, COOLDOWN_FRAMES);
   localparam logic [3:0] DMG = 4'(DMG_BASE);

   atk_state_t st [2];
   logic [1:0] req;
   logic [1:0] grant;
   logic [1:0] double_cd;
   logic       winner;
   logic       rr_reg, rr_next;
   logic       parry;
   logic       hit;
   logic       hit_valid_reg, hit_target_reg;
   logic [3:0] hit_dmg_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_player
      attack_timeline #(
         .WINDUP_FRAMES  (WINDUP_FRAMES),
         .COOLDOWN_FRAMES(COOLDOWN_FRAMES),
         .CW             (CW)
      ) u_timeline (
         .clk       (clk),
         .reset     (reset),
         .enable    (bus.enable),
         .frame_tick(bus.frame_tick),
         .atk_key   (bus.atk_req[gi]),
         .grant     (grant[gi]),
         .double_cd (double_cd[gi]),
         .strike_req(req[gi]),
         .state     (st[gi])
      );
   end

   // rr_ptr only moves when both players strike in the same cycle.
   always_comb begin
      grant   = 2'b00;
      winner  = 1'b0;
      rr_next = rr_reg;
      if (bus.enable) begin
         case (req)
            2'b01: begin grant = 2'b01; winner = 1'b0; end
            2'b10: begin grant = 2'b10; winner = 1'b1; end
            2'b11: begin
               winner  = rr_reg;
               grant   = rr_reg ? 2'b10 : 2'b01;
               rr_next = ~rr_reg;
            end
            default: ;
         endcase
      end
   end

`ifdef PARRY_EN
   assign parry = (|grant) & bus.touching & (st[~winner] == WINDUP);
`else
   assign parry = 1'b0;
`endif
   assign hit       = (|grant) & bus.touching & ~parry;
   assign double_cd = grant & {2{parry}};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_reg         <= 1'b0;
         hit_valid_reg  <= 1'b0;
         hit_target_reg <= 1'b0;
         hit_dmg_reg    <= 4'd0;
      end else begin
         rr_reg         <= rr_next;
         hit_valid_reg  <= hit;
         hit_target_reg <= hit & ~winner;
         hit_dmg_reg    <= hit ? DMG : 4'd0;
      end
   end

`ifdef PARRY_EN
   logic parry_reg;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) parry_reg <= 1'b0;
      else       parry_reg <= parry;
   end
   assign bus.parry_pulse = parry_reg & bus.enable;
`endif

   assign bus.hit_valid  = hit_valid_reg & bus.enable;
   assign bus.hit_target = hit_target_reg;
   assign bus.hit_dmg    = hit_dmg_reg;

   always_comb begin
      bus.busy    = 2'b00;
      bus.cooling = 2'b00;
      for (int i = 0; i < 2; i++) begin
         bus.busy[i]    = (st[i] != IDLE);
         bus.cooling[i] = (st[i] == COOLDOWN);
      end
   end

endmodule

// File: tb/tb_attack_scheduler.sv
// Directed bench for attack_scheduler with hand-computed expectations; the
// parry scenario is compiled in only when PARRY_EN is defined.
module tb_attack_scheduler;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   int   hit_cnt = 0;
   int   h0;

   attack_scheduler_if bus();

   attack_scheduler dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.hit_valid === 1'b1) hit_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         bus.frame_tick = 1'b1;
         step();
         bus.frame_tick = 1'b0;
      end
   endtask

   initial begin
      reset          = 1'b1;
      bus.enable     = 1'b0;
      bus.frame_tick = 1'b0;
      bus.atk_req    = 2'b00;
      bus.touching   = 1'b0;
      #1;
      check("rst_hit_valid", 32'(bus.hit_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_cooling", 32'(bus.cooling), 32'd0);
      check("rst_dmg", 32'(bus.hit_dmg), 32'd0);
      #11;
      reset      = 1'b0;
      bus.enable = 1'b1;
      step();

      // Single attack; the launch cycle also carries a frame tick.
      bus.touching   = 1'b1;
      bus.atk_req    = 2'b01;
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      check("single_launch_busy", 32'(bus.busy), 32'h1);
      tick(3);
      step();
      check("single_entry_tick_ignored", 32'(bus.hit_valid), 32'd0);
      tick(1);
      check("single_strike_no_hit", 32'(bus.hit_valid), 32'd0);
      check("single_strike_cooling", 32'(bus.cooling), 32'h0);
      check("single_strike_busy", 32'(bus.busy), 32'h1);
      step();
      check("single_hit_valid", 32'(bus.hit_valid), 32'd1);
      check("single_hit_target", 32'(bus.hit_target), 32'd1);
      check("single_hit_dmg", 32'(bus.hit_dmg), 32'd1);
      check("single_cooling", 32'(bus.cooling), 32'h1);
      step();
      check("single_pulse_one_cycle", 32'(bus.hit_valid), 32'd0);
      tick(29);
      check("single_cool_29", 32'(bus.cooling), 32'h1);
      tick(1);
      check("single_cool_30", 32'(bus.cooling), 32'h0);
      check("single_idle", 32'(bus.busy), 32'h0);

      // Whiff by c2, re-press during cooldown is dropped.
      bus.atk_req  = 2'b00;
      bus.touching = 1'b0;
      step();
      h0 = hit_cnt;
      bus.atk_req = 2'b10;
      step();
      tick(4);
      step();
      check("whiff_no_hit", 32'(bus.hit_valid), 32'd0);
      check("whiff_cooling", 32'(bus.cooling), 32'h2);
      bus.atk_req = 2'b00;
      step();
      bus.atk_req = 2'b10;
      step();
      tick(29);
      check("whiff_cool_29", 32'(bus.cooling), 32'h2);
      tick(1);
      check("whiff_repress_dropped", 32'(bus.busy), 32'h0);
      check("whiff_hit_count", 32'(hit_cnt - h0), 32'd0);
      bus.atk_req = 2'b00;
      step();
      bus.atk_req = 2'b10;
      step();
      check("whiff_new_press", 32'(bus.busy), 32'h2);
      bus.atk_req = 2'b00;
      bus.enable  = 1'b0;
      step();
      bus.enable = 1'b1;
      step();

      // Contention: rr_ptr starts at c1, then alternates.
      bus.touching = 1'b1;
      bus.atk_req  = 2'b11;
      step();
      tick(4);
      step();
      check("cont1_first_valid", 32'(bus.hit_valid), 32'd1);
      check("cont1_first_target", 32'(bus.hit_target), 32'd1);
      step();
      check("cont1_second_valid", 32'(bus.hit_valid), 32'd1);
      check("cont1_second_target", 32'(bus.hit_target), 32'd0);
      tick(30);
      check("cont1_idle", 32'(bus.busy), 32'h0);
      bus.atk_req = 2'b00;
      step();
      bus.atk_req = 2'b11;
      step();
      tick(4);
      step();
      check("cont2_first_target", 32'(bus.hit_target), 32'd0);
      check("cont2_first_valid", 32'(bus.hit_valid), 32'd1);
      step();
      check("cont2_second_target", 32'(bus.hit_target), 32'd1);
      check("cont2_second_valid", 32'(bus.hit_valid), 32'd1);
      tick(30);
      bus.atk_req = 2'b00;
      step();

      // Held key for 100 frames yields one hit.
      h0 = hit_cnt;
      bus.atk_req = 2'b01;
      step();
      tick(100);
      check("held_one_hit", 32'(hit_cnt - h0), 32'd1);
      check("held_idle", 32'(bus.busy), 32'h0);
      bus.atk_req = 2'b00;
      step();

      // Enable drop mid-windup, then relaunch with a fresh edge.
      bus.atk_req = 2'b01;
      step();
      tick(2);
      bus.enable = 1'b0;
      step();
      check("en_drop_busy", 32'(bus.busy), 32'h0);
      check("en_drop_hit", 32'(bus.hit_valid), 32'd0);
      bus.atk_req = 2'b00;
      step();
      bus.enable = 1'b1;
      step();
      h0 = hit_cnt;
      tick(6);
      check("en_restore_no_attack", 32'(bus.busy), 32'h0);
      check("en_restore_no_hit", 32'(hit_cnt - h0), 32'd0);
      bus.atk_req = 2'b01;
      step();
      check("en_new_edge", 32'(bus.busy), 32'h1);
      tick(4);
      step();
      check("en_hit_before_drop", 32'(bus.hit_valid), 32'd1);
      bus.enable = 1'b0;
      #1;
      check("en_hit_forced_low", 32'(bus.hit_valid), 32'd0);
      step();
      check("en_cooldown_cleared", 32'(bus.cooling), 32'h0);
      bus.atk_req = 2'b00;
      bus.enable  = 1'b1;
      step();

      // Async reset while cooling and with a hit pulse on the output.
      bus.atk_req = 2'b01;
      step();
      tick(4);
      step();
      check("ar_pre_hit", 32'(bus.hit_valid), 32'd1);
      check("ar_pre_cooling", 32'(bus.cooling), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_hit_valid", 32'(bus.hit_valid), 32'd0);
      check("ar_hit_target", 32'(bus.hit_target), 32'd0);
      check("ar_hit_dmg", 32'(bus.hit_dmg), 32'd0);
      check("ar_busy", 32'(bus.busy), 32'h0);
      check("ar_cooling", 32'(bus.cooling), 32'h0);
      bus.atk_req = 2'b00;
      step();
      reset = 1'b0;
      step();
      check("ar_after_release", 32'(bus.busy), 32'h0);

`ifdef PARRY_EN
      // c1 strikes while c2 is winding up.
      bus.touching = 1'b1;
      bus.atk_req  = 2'b01;
      step();
      tick(2);
      bus.atk_req = 2'b11;
      step();
      tick(2);
      step();
      check("parry_pulse", 32'(bus.parry_pulse), 32'd1);
      check("parry_no_hit", 32'(bus.hit_valid), 32'd0);
      check("parry_cooling", 32'(bus.cooling), 32'h1);
      tick(2);
      step();
      check("parry_c2_hit", 32'(bus.hit_valid), 32'd1);
      check("parry_c2_target", 32'(bus.hit_target), 32'd0);
      tick(57);
      check("parry_cool_59", 32'(bus.cooling[0]), 32'd1);
      tick(1);
      check("parry_cool_60", 32'(bus.cooling[0]), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
